// File: rtl/axi_eth_frame_bridge.sv
// AXI4-Lite register front end for an Ethernet MAC: framed TX FIFO toward the MAC,
// and an RX FIFO with a committed-length queue and rollback of bad frames.
module axi_eth_frame_bridge #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int TX_DEPTH  = 512,
    parameter int RX_DEPTH  = 512,
    parameter int RX_FRAMES = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] m_tx_data,
    output logic              m_tx_valid,
    output logic              m_tx_last,
    input  logic              m_tx_ready,
    input  logic [DATA_W-1:0] s_rx_data,
    input  logic              s_rx_valid,
    input  logic              s_rx_last,
    input  logic              s_rx_err,
    output logic              irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int LQ_AW = $clog2(RX_FRAMES);
    localparam int TX_PW = TX_AW + 1;
    localparam int RX_PW = RX_AW + 1;
    localparam int LQ_PW = LQ_AW + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_W:0]   tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RX_PW-1:0]  lq_mem [RX_FRAMES];

    logic [TX_PW-1:0] tx_wr, tx_rd, tx_frames, tx_used, tx_free;
    logic [RX_PW-1:0] rx_wr, rx_rd, rx_frame_start, rx_consumed;
    logic [RX_PW-1:0] rx_wr_inc, rx_len_new, rx_len_cur;
    logic [LQ_PW-1:0] lq_wr, lq_rd, rx_frames;
    logic             rx_bad;
    logic [2:0]       irq_en, irq_stat, irq_set, irq_w1c;
    logic [15:0]      drop_cnt;

    logic [2:0]        wr_sel, rd_sel;
    logic              wr_acc, rd_acc, wr_tx_sel, tx_push, tx_commit, tx_wr_err;
    logic              tx_empty, tx_full, tx_hs, tx_last_hs;
    logic [DATA_W:0]   tx_head;
    logic              rx_full, rx_wr_en, rx_drop, rx_commit, rx_pop;
    logic              lq_empty, lq_full;
    logic [DATA_W-1:0] rd_word;
    logic              rd_err;
    logic              unused_addr_bits;

    assign wr_sel  = awaddr[4:2];
    assign rd_sel  = araddr[4:2];
    assign wr_acc  = awvalid & wvalid & ~bvalid;
    assign rd_acc  = arvalid & ~rvalid;
    assign awready = wr_acc;
    assign wready  = wr_acc;
    assign arready = rd_acc;
    assign unused_addr_bits = ^{awaddr[ADDR_W-1:5], awaddr[1:0], araddr[ADDR_W-1:5], araddr[1:0]};

    assign tx_empty   = (tx_wr == tx_rd);
    assign tx_full    = (tx_wr[TX_AW-1:0] == tx_rd[TX_AW-1:0]) && (tx_wr[TX_AW] != tx_rd[TX_AW]);
    assign tx_used    = tx_wr - tx_rd;
    assign tx_free    = TX_PW'(TX_DEPTH) - tx_used;
    assign wr_tx_sel  = wr_acc && (wr_sel == 3'd0 || wr_sel == 3'd1);
    assign tx_push    = wr_tx_sel & ~tx_full;
    assign tx_commit  = tx_push && (wr_sel == 3'd1);
    assign tx_wr_err  = wr_tx_sel & tx_full;
    assign tx_head    = tx_mem[tx_rd[TX_AW-1:0]];
    // Words of an uncommitted frame are held back until its last word arrives.
    assign m_tx_valid = ~tx_empty && (tx_frames != '0);
    assign m_tx_data  = m_tx_valid ? tx_head[DATA_W-1:0] : '0;
    assign m_tx_last  = m_tx_valid & tx_head[DATA_W];
    assign tx_hs      = m_tx_valid & m_tx_ready;
    assign tx_last_hs = tx_hs & tx_head[DATA_W];

    assign rx_full    = (rx_wr[RX_AW-1:0] == rx_rd[RX_AW-1:0]) && (rx_wr[RX_AW] != rx_rd[RX_AW]);
    assign lq_empty   = (lq_wr == lq_rd);
    assign lq_full    = (lq_wr[LQ_AW-1:0] == lq_rd[LQ_AW-1:0]) && (lq_wr[LQ_AW] != lq_rd[LQ_AW]);
    assign rx_frames  = lq_wr - lq_rd;
    assign rx_wr_en   = s_rx_valid & ~rx_bad & ~rx_full;
    assign rx_wr_inc  = rx_wr + RX_PW'(1);
    assign rx_len_new = rx_wr_inc - rx_frame_start;
    assign rx_drop    = s_rx_valid & s_rx_last & (~rx_wr_en | s_rx_err | lq_full);
    assign rx_commit  = s_rx_valid & s_rx_last & ~(~rx_wr_en | s_rx_err | lq_full);
    assign rx_len_cur = lq_empty ? '0 : lq_mem[lq_rd[LQ_AW-1:0]] - rx_consumed;
    assign rx_pop     = rd_acc && (rd_sel == 3'd3) && ~lq_empty;

    assign irq_set = {rx_drop, tx_last_hs, rx_commit};
    assign irq_w1c = (wr_acc && wr_sel == 3'd6) ? wdata[2:0] : 3'b000;

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (rd_sel)
            3'd2: rd_word = DATA_W'({16'(rx_frames), 16'(tx_free)});
            3'd3: begin
                if (lq_empty) rd_err = 1'b1;
                else          rd_word = rx_mem[rx_rd[RX_AW-1:0]];
            end
            3'd4: rd_word = DATA_W'(rx_len_cur);
            3'd5: rd_word = DATA_W'(irq_en);
            3'd6: rd_word = DATA_W'(irq_stat);
            3'd7: rd_word = DATA_W'(drop_cnt);
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (tx_push)   tx_mem[tx_wr[TX_AW-1:0]] <= {tx_commit, wdata};
        if (rx_wr_en)  rx_mem[rx_wr[RX_AW-1:0]] <= s_rx_data;
        if (rx_commit) lq_mem[lq_wr[LQ_AW-1:0]] <= rx_len_new;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bvalid <= 1'b0;  bresp <= RESP_OKAY;
            rvalid <= 1'b0;  rresp <= RESP_OKAY;  rdata <= '0;
            tx_wr <= '0;  tx_rd <= '0;  tx_frames <= '0;
            rx_wr <= '0;  rx_rd <= '0;  rx_frame_start <= '0;  rx_consumed <= '0;
            lq_wr <= '0;  lq_rd <= '0;  rx_bad <= 1'b0;
            irq_en <= '0;  irq_stat <= '0;  drop_cnt <= '0;  irq <= 1'b0;
        end else begin
            if (wr_acc) begin
                bvalid <= 1'b1;
                bresp  <= tx_wr_err ? RESP_SLVERR : RESP_OKAY;
                if (wr_sel == 3'd5) irq_en <= wdata[2:0];
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end

            if (rd_acc) begin
                rvalid <= 1'b1;
                rdata  <= rd_word;
                rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end

            if (tx_push) tx_wr <= tx_wr + TX_PW'(1);
            if (tx_hs)   tx_rd <= tx_rd + TX_PW'(1);
            case ({tx_commit, tx_last_hs})
                2'b10:   tx_frames <= tx_frames + TX_PW'(1);
                2'b01:   tx_frames <= tx_frames - TX_PW'(1);
                default: tx_frames <= tx_frames;
            endcase

            // A rejected frame rewinds the write pointer to the last committed boundary.
            if (s_rx_valid) begin
                if (s_rx_last) begin
                    rx_bad <= 1'b0;
                    if (rx_drop) begin
                        rx_wr <= rx_frame_start;
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                    end else begin
                        rx_wr          <= rx_wr_inc;
                        rx_frame_start <= rx_wr_inc;
                        lq_wr          <= lq_wr + LQ_PW'(1);
                    end
                end else if (rx_wr_en) begin
                    rx_wr <= rx_wr_inc;
                end else begin
                    rx_bad <= 1'b1;
                end
            end

            if (rx_pop) begin
                rx_rd <= rx_rd + RX_PW'(1);
                if (rx_len_cur == RX_PW'(1)) begin
                    lq_rd       <= lq_rd + LQ_PW'(1);
                    rx_consumed <= '0;
                end else begin
                    rx_consumed <= rx_consumed + RX_PW'(1);
                end
            end

            irq_stat <= (irq_stat & ~irq_w1c) | irq_set;
            irq      <= |(irq_stat & irq_en);
        end
    end
endmodule

// File: tb/tb_axi_eth_frame_bridge.sv
// Directed self-checking bench for axi_eth_frame_bridge: register access, TX framing,
// RX commit/rollback, overflow and interrupt behaviour with default parameters.
`timescale 1ns/1ps
module tb_axi_eth_frame_bridge;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [DATA_W-1:0] wdata = '0, s_rx_data = '0;
    logic              s_rx_valid = 1'b0, s_rx_last = 1'b0, s_rx_err = 1'b0, m_tx_ready = 1'b0;
    logic              awready, wready, bvalid, arready, rvalid, m_tx_valid, m_tx_last, irq;
    logic [1:0]        bresp, rresp;
    logic [DATA_W-1:0] rdata, m_tx_data;

    int n_checks = 0;
    int n_errors = 0;

    axi_eth_frame_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TX_DEPTH(512), .RX_DEPTH(512), .RX_FRAMES(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .m_tx_data(m_tx_data), .m_tx_valid(m_tx_valid), .m_tx_last(m_tx_last), .m_tx_ready(m_tx_ready),
        .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid), .s_rx_last(s_rx_last), .s_rx_err(s_rx_err),
        .irq(irq)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int n;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) check("aw_timeout", 32'(n), 0);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) check("b_timeout", 32'(n), 0);
        resp = bresp;
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) check("ar_timeout", 32'(n), 0);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
        if (n >= 20) check("r_timeout", 32'(n), 0);
        data = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    task automatic reg_wr(input string tag, input logic [7:0] addr, input logic [31:0] data);
        logic [1:0] resp;
        axi_write(addr, data, resp);
        check(tag, 32'(resp), 0);
    endtask

    task automatic reg_rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  resp;
        axi_read(addr, d, resp);
        check(tag, d, exp);
    endtask

    task automatic rx_frame(input int n, input logic [31:0] base, input bit err);
        for (int i = 0; i < n; i++) begin
            s_rx_valid = 1'b1;
            s_rx_data  = base + 32'(i);
            s_rx_last  = (i == n - 1);
            s_rx_err   = (i == n - 1) && err;
            @(posedge aclk); #1;
        end
        s_rx_valid = 1'b0; s_rx_last = 1'b0; s_rx_err = 1'b0;
    endtask

    task automatic tx_beat(input string tag, input logic [31:0] exp_data, input logic exp_last);
        check({tag, "_valid"}, 32'(m_tx_valid), 1);
        check({tag, "_data"}, m_tx_data, exp_data);
        check({tag, "_last"}, 32'(m_tx_last), 32'(exp_last));
        m_tx_ready = 1'b1;
        @(posedge aclk); #1;
        m_tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        int          nbad;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("reset_ctrl_outputs",
              32'({awready, wready, bvalid, bresp, arready, rvalid, rresp, m_tx_valid, m_tx_last, irq}), 0);
        check("reset_rdata", rdata, 0);
        check("reset_m_tx_data", m_tx_data, 0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        reg_rd("reset_status", 8'h08, 32'h0000_0200);
        reg_rd("reset_rx_len", 8'h10, 0);

        // TX: uncommitted words are held, commit releases four beats
        reg_wr("tx_w0", 8'h00, 32'h11);
        reg_wr("tx_w1", 8'h00, 32'h22);
        reg_wr("tx_w2", 8'h00, 32'h33);
        repeat (3) @(posedge aclk);
        #1;
        check("tx_uncommitted_valid", 32'(m_tx_valid), 0);
        reg_wr("tx_last_w", 8'h04, 32'hDEAD_BEEF);
        tx_beat("tx_b1", 32'h11, 1'b0);
        tx_beat("tx_b2", 32'h22, 1'b0);
        tx_beat("tx_b3", 32'h33, 1'b0);
        tx_beat("tx_b4", 32'hDEAD_BEEF, 1'b1);
        check("tx_drained_valid", 32'(m_tx_valid), 0);
        reg_rd("tx_irq_stat", 8'h18, 32'h2);
        reg_wr("tx_w1c", 8'h18, 32'h2);
        reg_rd("tx_irq_stat_clr", 8'h18, 32'h0);
        reg_rd("tx_status_free", 8'h08, 32'h0000_0200);

        // RX: good 5-word frame read back in order
        rx_frame(5, 32'hA0, 1'b0);
        reg_rd("rx5_status", 8'h08, 32'h0001_0200);
        reg_rd("rx5_len", 8'h10, 5);
        for (int i = 0; i < 5; i++) begin
            axi_read(8'h0C, d, resp);
            check("rx5_data", d, 32'hA0 + 32'(i));
            check("rx5_resp", 32'(resp), 0);
        end
        reg_rd("rx5_len_after", 8'h10, 0);
        axi_read(8'h0C, d, resp);
        check("rx_empty_resp", 32'(resp), 2);
        check("rx_empty_data", d, 0);
        reg_rd("rx5_irq_stat", 8'h18, 32'h1);
        reg_wr("rx5_w1c", 8'h18, 32'h7);

        // RX: errored frame is rolled back, next frame intact
        rx_frame(4, 32'hB0, 1'b1);
        reg_rd("rxerr_drop_cnt", 8'h1C, 1);
        reg_rd("rxerr_len", 8'h10, 0);
        reg_rd("rxerr_irq_stat", 8'h18, 32'h4);
        rx_frame(2, 32'hC0, 1'b0);
        reg_rd("rx2_len", 8'h10, 2);
        reg_rd("rx2_d0", 8'h0C, 32'hC0);
        reg_rd("rx2_d1", 8'h0C, 32'hC1);
        reg_rd("rx2_len_after", 8'h10, 0);

        // RX: oversize frame overflows and is dropped; length queue limit
        do_reset();
        rx_frame(600, 32'h1000, 1'b0);
        reg_rd("ovf_drop_cnt", 8'h1C, 1);
        reg_rd("ovf_status", 8'h08, 32'h0000_0200);
        reg_rd("ovf_len", 8'h10, 0);
        for (int i = 0; i < 17; i++) rx_frame(1, 32'hD0 + 32'(i), 1'b0);
        reg_rd("lq_status", 8'h08, 32'h0010_0200);
        reg_rd("lq_drop_cnt", 8'h1C, 2);
        reg_rd("lq_len", 8'h10, 1);
        reg_rd("lq_first_word", 8'h0C, 32'hD0);
        reg_rd("lq_status_after_pop", 8'h08, 32'h000F_0200);

        // TX overflow and interrupt behaviour
        do_reset();
        nbad = 0;
        for (int i = 0; i < 512; i++) begin
            axi_write(8'h00, 32'(i), resp);
            if (resp != 2'b00) nbad++;
        end
        check("tx_fill_okay", 32'(nbad), 0);
        axi_write(8'h00, 32'hFFFF, resp);
        check("tx_full_slverr", 32'(resp), 2);
        reg_rd("tx_full_status", 8'h08, 32'h0);
        check("tx_full_uncommitted", 32'(m_tx_valid), 0);

        reg_wr("irq_en_w", 8'h14, 32'h1);
        reg_rd("irq_en_r", 8'h14, 32'h1);
        check("irq_idle", 32'(irq), 0);
        s_rx_valid = 1'b1; s_rx_last = 1'b1; s_rx_data = 32'h55;
        @(posedge aclk); #1;
        s_rx_valid = 1'b0; s_rx_last = 1'b0;
        check("irq_same_cycle", 32'(irq), 0);
        @(posedge aclk); #1;
        check("irq_next_cycle", 32'(irq), 1);

        // W1C colliding with a new commit: hardware set wins
        awaddr = 8'h18; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
        s_rx_valid = 1'b1; s_rx_last = 1'b1; s_rx_data = 32'h66;
        #1;
        check("collide_awready", 32'(awready), 1);
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; s_rx_valid = 1'b0; s_rx_last = 1'b0;
        check("collide_bvalid", 32'(bvalid), 1);
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        reg_rd("collide_irq_stat", 8'h18, 32'h1);
        check("collide_irq", 32'(irq), 1);
        reg_wr("final_w1c", 8'h18, 32'h1);
        reg_rd("final_irq_stat", 8'h18, 32'h0);
        check("final_irq", 32'(irq), 0);
        reg_rd("final_rx_frames", 8'h08, 32'h0002_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
